// File: rtl/fifo_rd_prefetch_pkg.sv
// Shared definitions for the FIFO read-prefetch stage.
//   DAT_WIDTH_DEF : default width of FIFO read data / output data
//   CNT_WIDTH_DEF : default width of the delivered-word counter
//   occ_t         : occupancy type (words held plus word in flight, 0..2)
package fifo_rd_prefetch_pkg;

  localparam int DAT_WIDTH_DEF = 37;
  localparam int CNT_WIDTH_DEF = 16;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry ordered buffer (head, tail) behind the FIFO read port.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data into the first free slot
//   push_data    : word to write
//   pop          : drop the head, tail moves to head
//   clr          : empty the buffer (wins over push/pop)
//   head         : current head word
//   count        : number of words held (0..2)
module fifo_rd_skid_buf
  import fifo_rd_prefetch_pkg::*;
#(
  parameter int DAT_WIDTH = DAT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [DAT_WIDTH-1:0] push_data,
  input  logic                 pop,
  input  logic                 clr,
  output logic [DAT_WIDTH-1:0] head,
  output occ_t                 count
);

  logic [DAT_WIDTH-1:0] head_q;
  logic [DAT_WIDTH-1:0] tail_q;
  occ_t                 count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: count is unchanged, the new word
          // lands behind whatever survives the pop.
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-prefetch stage between a FIFO controller/RAM and a valid/ready consumer.
// Issues reads while there is room for the returning word, stores returned
// words in a two-entry buffer and presents the head to the consumer.
//   clk, reset_n  : clock, asynchronous active-low reset
//   fifo_empty    : upstream FIFO empty flag
//   fifo_rd_op    : read strobe / RAM read enable
//   fifo_rd_data  : RAM data, valid the cycle after fifo_rd_op
//   clr           : synchronous flush of this stage
//   out_valid     : head word presented on out_data
//   out_ready     : consumer accepts the head word
//   out_data      : head word
//   occupancy     : words held plus word in flight
//   delivered_cnt : accepted words, wraps
module fifo_rd_prefetch
  import fifo_rd_prefetch_pkg::*;
#(
  parameter int DAT_WIDTH = DAT_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_op,
  input  logic [DAT_WIDTH-1:0] fifo_rd_data,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DAT_WIDTH-1:0] out_data,
  output occ_t                 occupancy,
  output logic [CNT_WIDTH-1:0] delivered_cnt
);

  occ_t                 held;
  logic [DAT_WIDTH-1:0] head;
  logic                 run_q;
  logic                 inflight_q;
  logic                 discard_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 transfer;
  logic                 push;
  logic [2:0]           need;

  assign out_valid = (held != 2'd0);
  assign out_data  = head;
  assign transfer  = out_valid & out_ready & ~clr;

  // Room check counts the word already in flight and credits a transfer in
  // this same cycle, so a full buffer that is draining keeps reads flowing.
  assign need       = 3'(held) + 3'(inflight_q) - 3'(transfer);
  // run_q keeps reads off until the first edge after reset release.
  assign fifo_rd_op = run_q & ~fifo_empty & ~clr & (need < 3'd2);

  // A returning word is dropped if a flush hits in the cycle it arrives or
  // if it belongs to a read that was outstanding across a flush.
  assign push = inflight_q & ~clr & ~discard_q;

  fifo_rd_skid_buf #(
    .DAT_WIDTH(DAT_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (transfer),
    .clr       (clr),
    .head      (head),
    .count     (held)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= fifo_rd_op;
      discard_q  <= clr & inflight_q;
      if (transfer) cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign occupancy     = held + {1'b0, inflight_q};
  assign delivered_cnt = cnt_q;

endmodule

// File: doc/fifo_rd_prefetch.md
FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

Interface
REQ-001 Parameter DAT_WIDTH, default 37: width of the FIFO read data and the output data.
REQ-002 Parameter CNT_WIDTH, default 16: width of the delivered-word counter.
REQ-003 Port clk, input, 1: single clock; all state is on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port fifo_empty, input, 1: empty flag from the upstream FIFO controller.
REQ-006 Port fifo_rd_op, output, 1: read strobe to the FIFO controller and RAM read enable.
REQ-007 Port fifo_rd_data, input, DAT_WIDTH: RAM read data, valid in the cycle after fifo_rd_op.
REQ-008 Port clr, input, 1: synchronous flush of this stage.
REQ-009 Port out_valid, output, 1: the head word is presented on out_data.
REQ-010 Port out_ready, input, 1: the consumer accepts the head word.
REQ-011 Port out_data, output, DAT_WIDTH: head word.
REQ-012 Port occupancy, output, 2: number of words held plus the word in flight (0..2).
REQ-013 Port delivered_cnt, output, CNT_WIDTH: count of accepted words; wraps modulo 2^CNT_WIDTH.

Function
REQ-014 The stage SHALL hold a 2-entry ordered buffer (head, tail) and a 1-bit in-flight flag.
REQ-015 A transfer SHALL occur in a cycle where out_valid=1 and out_ready=1; the head is then popped and the tail moves to the head.
REQ-016 fifo_rd_op SHALL equal !fifo_empty && !clr && (held + inflight - transfer) < 2; out_ready may reach fifo_rd_op combinationally.
REQ-017 A fifo_rd_op asserted in cycle N SHALL set inflight for cycle N+1; in cycle N+1 fifo_rd_data SHALL be written to the first free slot at the clock edge that ends that cycle.
REQ-018 Read latency: with the stage empty, fifo_rd_op in cycle N SHALL give out_valid=1 with that word from cycle N+2.
REQ-019 With out_ready held at 1 and fifo_empty held at 0, the stage SHALL sustain one transfer per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_valid SHALL stay stable.
REQ-021 Words SHALL leave in FIFO order; none SHALL be duplicated or dropped, except as stated in REQ-023 and REQ-024.
REQ-022 Writing a word into the buffer and a transfer in the same cycle SHALL both take effect; held changes by +1, 0 or -1 as appropriate.
REQ-023 clr=1 SHALL empty the buffer at the next edge, force fifo_rd_op=0 and block any transfer in that cycle.
REQ-024 A word that arrives in the cycle after a clr while inflight=1 SHALL be discarded; the loss of that FIFO entry is defined behaviour.
REQ-025 delivered_cnt SHALL increment by 1 on each transfer.
REQ-026 held + inflight > 2 SHALL never occur; the bench asserts this.

Reset
REQ-027 While reset_n=0, out_valid, fifo_rd_op, occupancy, delivered_cnt, inflight and the discard flag SHALL be 0; out_data SHALL be all zeros.
REQ-028 Reset SHALL take effect asynchronously at any time, including with a read in flight; a word returning after reset release SHALL be ignored.
REQ-029 The first fifo_rd_op SHALL occur no earlier than the first clock edge after reset_n rises.

Structure
REQ-030 The defaults for DAT_WIDTH and CNT_WIDTH, and the 2-bit occupancy type, SHALL live in a shared package, fifo_rd_prefetch_pkg.
REQ-031 The 2-entry storage SHALL be one sub-module, fifo_rd_skid_buf: push, pop, clr, head, count.
REQ-032 The top level SHALL hold the read-issue logic, the in-flight and discard flags, and the counter.

Verification
REQ-033 Reset, then fifo_empty falls in cycle 0 with out_ready=1 -> fifo_rd_op=1 in cycle 0; out_valid=1 with word 0 in cycle 2; delivered_cnt=1 after cycle 2.
REQ-034 Preload 8 words 0x0..0x7, out_ready=1 throughout -> 8 back-to-back transfers in order; fifo_rd_op high 8 consecutive cycles; delivered_cnt=8.
REQ-035 out_ready=0 with 4 words available -> exactly 2 reads issued, occupancy=2, out_data stable; raising out_ready gives in-order delivery with no gap.
REQ-036 clr asserted in the cycle after a read, buffer holding 1 word -> occupancy=0 two cycles later; no out_valid from the discarded word; the next read delivers the next FIFO word.
REQ-037 reset_n dropped mid-stream with inflight=1 -> all outputs 0 immediately; after release, the first delivered word is a newly read word.
REQ-038 delivered_cnt preloaded near 0xFFFF by forcing, then 2 transfers -> wraps to 0x0001.
